// File: rtl/rr_arb_mux.sv
// -----------------------------------------------------------------------------
// rr_arb_mux
//
// N-channel, W-bit arbitrated multiplexer with valid/ready handshakes on every
// channel and a single registered output slot. Two selection modes:
//   mode = 0 : static, the channel named by `sel` is offered the slot
//              (an index >= CHANNELS grants nobody)
//   mode = 1 : round-robin, the first valid channel at or above `rr_ptr`
//              (wrapping) is granted; after a transfer the pointer moves just
//              past the winner.
//
// Optional feature (compile-time macro RR_ARB_MUX_LOCK_EN):
//   packet lock. A beat accepted with in_last = 0 pins the grant to that
//   channel in both modes until a beat with in_last = 1 is accepted from it.
//   Without the macro, in_last is ignored and no lock state exists.
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous active-low reset
//   in_data    CHANNELS*WIDTH flattened inputs, channel k at [k*WIDTH +: WIDTH]
//   in_valid   per-channel request
//   in_ready   per-channel accept, at most one bit high
//   in_last    per-channel end-of-packet (lock build only)
//   mode       0 = static select, 1 = round-robin
//   sel        channel index used in static mode
//   out_data   registered data of the held beat
//   out_valid  registered valid
//   out_ready  downstream accept
//   out_sel    registered index of the channel that supplied out_data
// -----------------------------------------------------------------------------
module rr_arb_mux #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 32,
    // Derived from CHANNELS; leave at its default.
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [CHANNELS-1:0]       in_last,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_sel
);

    // Unpacked view of the flattened input bus.
    logic [WIDTH-1:0] chan_data [CHANNELS];

    for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
        assign chan_data[k] = in_data[k*WIDTH +: WIDTH];
    end

    logic             load;      // output slot can take a beat this cycle
    logic             cand_ok;   // candidate index is a real channel
    logic             xfer;      // handshake completes this cycle
    logic             advance;   // round-robin pointer moves this cycle
    logic [SEL_W-1:0] cand;
    logic [SEL_W-1:0] rr_cand;
    logic             rr_found;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] next_ptr;
    logic             locked;
    logic [SEL_W-1:0] locked_ch;
    int               idx;

    assign load = !out_valid || out_ready;

    // Round-robin search: walk CHANNELS positions upward from rr_ptr,
    // wrapping, and keep the first requester seen.
    // NOTE: every variable driven here gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin : rr_search
        rr_found = 1'b0;
        rr_cand  = rr_ptr;
        idx      = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (!rr_found && in_valid[SEL_W'(idx)]) begin
                rr_found = 1'b1;
                rr_cand  = SEL_W'(idx);
            end
        end
    end

    // An active lock overrides both modes; mode and sel are ignored until
    // the packet's last beat has been accepted.
    always_comb begin : candidate
        cand    = '0;
        cand_ok = 1'b0;
        if (locked) begin
            cand    = locked_ch;
            cand_ok = 1'b1;
        end else if (!mode) begin
            cand    = sel;
            cand_ok = (int'(sel) < CHANNELS);
        end else begin
            cand    = rr_cand;
            cand_ok = rr_found;
        end
    end

    // Static mode offers the slot whether or not the channel is requesting;
    // round-robin only raises ready on the channel it actually picked.
    always_comb begin : ready_gen
        in_ready = '0;
        if (cand_ok && load) in_ready[cand] = mode ? in_valid[cand] : 1'b1;
    end

    assign xfer     = cand_ok && load && in_valid[cand];
    assign next_ptr = (cand == SEL_W'(CHANNELS - 1)) ? '0 : cand + SEL_W'(1);

`ifdef RR_ARB_MUX_LOCK_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            locked    <= 1'b0;
            locked_ch <= '0;
        end else if (xfer) begin
            locked    <= !in_last[cand];
            locked_ch <= cand;
        end
    end

    // The pointer stays put for the body of a packet and moves on its last beat.
    assign advance = xfer && mode && in_last[cand];
`else
    assign locked    = 1'b0;
    assign locked_ch = '0;
    assign advance   = xfer && mode;

    logic unused_last;
    assign unused_last = ^in_last;
`endif

    // Output slot and round-robin pointer.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            rr_ptr    <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= chan_data[cand];
                out_sel   <= cand;
            end else if (load) begin
                out_valid <= 1'b0;
            end
            if (advance) rr_ptr <= next_ptr;
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// -----------------------------------------------------------------------------
// tb_rr_arb_mux
//
// Self-checking bench for rr_arb_mux. A 4-channel instance is driven through
// directed steps (reset, static select, round-robin order, backpressure,
// wrap/skip, mode switching, mid-stream reset, packet lock when
// RR_ARB_MUX_LOCK_EN is defined) followed by a randomized phase, all compared
// against a behavioural model of the arbitration rules. A 3-channel instance
// covers the out-of-range static select.
// -----------------------------------------------------------------------------
module tb_rr_arb_mux;

`ifdef RR_ARB_MUX_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset;

    // 4-channel instance
    logic [31:0]  dat [4];
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [3:0]   in_last;
    logic         mode;
    logic [1:0]   sel;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_sel;

    // 3-channel instance
    logic [95:0]  c3_data;
    logic [2:0]   c3_valid;
    logic [2:0]   c3_ready;
    logic [2:0]   c3_last;
    logic         c3_mode;
    logic [1:0]   c3_sel;
    logic [31:0]  c3_out_data;
    logic         c3_out_valid;
    logic         c3_out_ready;
    logic [1:0]   c3_out_sel;

    int checks = 0;
    int errors = 0;

    assign in_data = {dat[3], dat[2], dat[1], dat[0]};

    always #5 clock = ~clock;

    rr_arb_mux #(.CHANNELS(4), .WIDTH(32)) dut4 (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel)
    );

    rr_arb_mux #(.CHANNELS(3), .WIDTH(32)) dut3 (
        .clock     (clock),
        .reset     (reset),
        .in_data   (c3_data),
        .in_valid  (c3_valid),
        .in_ready  (c3_ready),
        .in_last   (c3_last),
        .mode      (c3_mode),
        .sel       (c3_sel),
        .out_data  (c3_out_data),
        .out_valid (c3_out_valid),
        .out_ready (c3_out_ready),
        .out_sel   (c3_out_sel)
    );

    // ---------------- behavioural reference model (4 channels) -------------
    bit          m_valid;
    logic [31:0] m_data;
    int          m_sel;
    int          m_ptr;
    bit          m_lock;
    int          m_lock_ch;
    logic [3:0]  obs_ready;

    task automatic model_reset();
        m_valid   = 1'b0;
        m_data    = '0;
        m_sel     = 0;
        m_ptr     = 0;
        m_lock    = 1'b0;
        m_lock_ch = 0;
    endtask

    // Which channel is offered the slot, and the ready vector that implies.
    task automatic model_grant(output logic [3:0] rdy, output int g);
        bit         slot_free;
        logic [1:0] gi;
        slot_free = !m_valid || out_ready;
        rdy = '0;
        g   = -1;
        if (m_lock) begin
            g = m_lock_ch;
        end else if (!mode) begin
            g = int'(sel);
        end else begin
            for (int k = 0; k < 4; k++) begin
                gi = 2'((m_ptr + k) % 4);
                if (g < 0 && in_valid[gi]) g = (m_ptr + k) % 4;
            end
        end
        if (slot_free && g >= 0) begin
            gi = 2'(g);
            if (!mode) rdy = 4'b0001 << g;
            else if (in_valid[gi]) rdy = 4'b0001 << g;
        end
    endtask

    task automatic model_update(input bit xf, input int g);
        logic [1:0] gi;
        gi = 2'(g);
        if (xf) begin
            m_valid = 1'b1;
            m_data  = dat[gi];
            m_sel   = g;
            if (mode && (!LOCK || in_last[gi])) m_ptr = (g + 1) % 4;
            if (LOCK) begin
                m_lock    = !in_last[gi];
                m_lock_ch = g;
            end
        end else if (!m_valid || out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    // ---------------- checking helpers --------------------------------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the inputs already driven: check the combinational
    // ready, advance the model across the edge, then check the output slot.
    task automatic cycle();
        logic [3:0] er;
        int         g;
        bit         xf;
        #1;
        model_grant(er, g);
        obs_ready = in_ready;
        check("in_ready", 64'(in_ready), 64'(er));
        xf = 1'b0;
        if (g >= 0) xf = er[2'(g)] && in_valid[2'(g)];
        @(posedge clock);
        model_update(xf, g);
        #1;
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("out_sel", 64'(out_sel), 64'(m_sel));
        check("out_data", 64'(out_data), 64'(m_data));
    endtask

    // Called just after a rising edge; asserts reset mid-cycle and releases it
    // one edge later.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check("async_rst_valid", 64'(out_valid), 64'(0));
        check("async_rst_data", 64'(out_data), 64'(0));
        check("async_rst_sel", 64'(out_sel), 64'(0));
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    // ---------------- stimulus ----------------------------------------------
    logic [31:0] last_d3;

    initial begin
        reset     = 1'b0;
        in_valid  = '0;
        in_last   = '1;
        mode      = 1'b1;
        sel       = '0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) dat[k] = '0;
        c3_data      = {3{32'h0BAD_F00D}};
        c3_valid     = '0;
        c3_last      = '1;
        c3_mode      = 1'b0;
        c3_sel       = '0;
        c3_out_ready = 1'b1;
        model_reset();

        // Reset state
        @(posedge clock);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_sel", 64'(out_sel), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(0));
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Static select of channel 2
        mode     = 1'b0;
        sel      = 2'd2;
        in_valid = 4'b0100;
        dat[0]   = $urandom;
        dat[1]   = $urandom;
        dat[2]   = 32'hA5A5_A5A5;
        dat[3]   = $urandom;
        cycle();
        check("static_ready", 64'(obs_ready), 64'(4'b0100));
        check("static_data", 64'(out_data), 64'(32'hA5A5_A5A5));
        check("static_sel", 64'(out_sel), 64'(2));

        // Round-robin fairness with all channels requesting
        mode     = 1'b1;
        in_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4; k++) dat[k] = $urandom;
            last_d3 = dat[3];
            cycle();
            check("rr_order", 64'(out_sel), 64'(i % 4));
        end

        // Backpressure: slot holds the channel-3 beat for 5 cycles
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 4; k++) dat[k] = $urandom;
            cycle();
            check("bp_ready", 64'(obs_ready), 64'(0));
            check("bp_hold_sel", 64'(out_sel), 64'(3));
            check("bp_hold_data", 64'(out_data), 64'(last_d3));
        end
        out_ready = 1'b1;
        cycle();
        check("bp_release_valid", 64'(out_valid), 64'(1));
        check("bp_release_sel", 64'(out_sel), 64'(0));

        // Wrap and skip: pointer 1 -> ch2 (ptr 3) -> only ch1 valid -> ptr 2
        in_valid = 4'b0100;
        cycle();
        check("wrap_pre_sel", 64'(out_sel), 64'(2));
        in_valid = 4'b0010;
        cycle();
        check("wrap_ready", 64'(obs_ready), 64'(4'b0010));
        check("wrap_sel", 64'(out_sel), 64'(1));
        in_valid = 4'b1111;
        cycle();
        check("wrap_ptr2_sel", 64'(out_sel), 64'(2));

        // Mode change takes effect immediately; pointer survives static mode
        mode = 1'b0;
        sel  = 2'd1;
        cycle();
        check("mode_static_sel", 64'(out_sel), 64'(1));
        mode = 1'b1;
        cycle();
        check("mode_rr_ptr_kept", 64'(out_sel), 64'(3));

        // Reset mid-stream, then the lowest valid channel wins
        do_reset();
        in_valid = 4'b1111;
        cycle();
        check("post_rst_sel", 64'(out_sel), 64'(0));

`ifdef RR_ARB_MUX_LOCK_EN
        // Packet lock: three channel-0 beats before channel 1 gets a turn
        do_reset();
        mode     = 1'b1;
        in_valid = 4'b0011;
        in_last  = 4'b0000;
        cycle();
        check("lock_beat0", 64'(out_sel), 64'(0));
        cycle();
        check("lock_beat1", 64'(out_sel), 64'(0));
        in_last = 4'b0001;
        cycle();
        check("lock_beat2", 64'(out_sel), 64'(0));
        in_last = 4'b1111;
        cycle();
        check("lock_next_ch", 64'(out_sel), 64'(1));
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            in_valid  = 4'($urandom);
            mode      = ($urandom_range(3) != 0);
            sel       = 2'($urandom);
            out_ready = ($urandom_range(3) != 0);
            in_last   = 4'($urandom);
            for (int k = 0; k < 4; k++) dat[k] = $urandom;
            cycle();
        end

        // 3-channel instance: static select out of range grants nobody
        c3_mode      = 1'b0;
        c3_sel       = 2'd1;
        c3_valid     = 3'b111;
        c3_out_ready = 1'b0;
        #1;
        check("c3_sel1_ready", 64'(c3_ready), 64'(3'b010));
        @(posedge clock);
        #1;
        check("c3_pending_valid", 64'(c3_out_valid), 64'(1));
        check("c3_pending_sel", 64'(c3_out_sel), 64'(1));
        c3_sel = 2'd3;
        #1;
        check("c3_oor_ready_bp", 64'(c3_ready), 64'(0));
        @(posedge clock);
        #1;
        check("c3_oor_hold_valid", 64'(c3_out_valid), 64'(1));
        c3_out_ready = 1'b1;
        #1;
        check("c3_oor_ready", 64'(c3_ready), 64'(0));
        @(posedge clock);
        #1;
        check("c3_oor_drain_valid", 64'(c3_out_valid), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
# rr_arb_mux

Parametrised N-channel, W-bit arbitrated multiplexer with valid/ready handshakes and a registered output stage. It generalises the fixed 4:1 select mux used in the datapath to any channel count, and adds two selection modes: a static mode driven by an external `sel`, and a round-robin mode that arbitrates among requesting channels. It sits wherever several producers share one consumer, such as instruction-fetch versus load/store requests into the memory port.

## Interface
- `CHANNELS`, default 4: number of input channels, ≥2.
- `WIDTH`, default 32: data width per channel.
- `SEL_W`, default `$clog2(CHANNELS)`: width of the select and grant indices. Derived; not overridden.
- `clock`  in  1: rising-edge clock. This is the single clock of the block.
- `reset`  in  1: asynchronous, active-low reset.
- `in_data`  in  CHANNELS*WIDTH: flattened inputs; channel k occupies bits [k*WIDTH +: WIDTH].
- `in_valid`  in  CHANNELS: per-channel request.
- `in_ready`  out  CHANNELS: per-channel accept. At most one bit is high per cycle.
- `in_last`  in  CHANNELS: last beat of a packet. Used only when `RR_ARB_MUX_LOCK_EN` is defined.
- `mode`  in  1: 0 = static select, 1 = round-robin.
- `sel`  in  SEL_W: channel index used in static mode.
- `out_data`  out  WIDTH: registered data.
- `out_valid`  out  1: registered valid.
- `out_ready`  in  1: downstream accept.
- `out_sel`  out  SEL_W: registered index of the channel whose beat is in `out_data`.

## Operation
- Output stage is a single register slot. `load = !out_valid || out_ready`.
- Static mode: the candidate is `sel`. `in_ready[sel] = load`. If `sel >= CHANNELS`, no channel is granted.
- Round-robin mode: the candidate is the first channel with `in_valid` high, searching upward from pointer `rr_ptr` and wrapping from CHANNELS-1 to 0. `in_ready[cand] = load && in_valid[cand]`.
- A transfer happens when `in_valid[g] && in_ready[g]`. On a transfer, `out_data`, `out_sel` and `out_valid` load from channel g on the next edge.
- Round-robin pointer update: after a transfer from g, `rr_ptr` becomes g+1, wrapping to 0 after CHANNELS-1. The pointer is not updated in static mode or on cycles with no transfer.
- When `load` is high and no transfer occurs, `out_valid` clears.
- When `out_valid` is high and `out_ready` is low, `out_data`, `out_sel` and `out_valid` hold and all `in_ready` bits are 0.
- A change of `mode` takes effect in the same cycle. `rr_ptr` is preserved across mode changes.
- A dropped `in_valid` with no transfer has no side effects.

## Timing
- Input-to-output latency is 1 cycle.
- Sustained throughput is 1 beat per cycle when `out_ready` is held high.
- `in_ready` is combinational from `in_valid`, `mode`, `sel`, `out_valid`, `out_ready` and internal state. It does not depend on `in_data`.
- Reset values (asserted asynchronously): `out_valid = 0`, `out_data = 0`, `out_sel = 0`, `rr_ptr = 0`, lock state cleared.
- Reset asserted mid-stream: an in-flight output beat is dropped. The first grant after release goes to the lowest valid channel (round-robin) or to `sel` (static).
- Simultaneous events: output consumption and input capture in the same cycle give back-to-back beats with no bubble.

## Configuration
- `RR_ARB_MUX_LOCK_EN` defined: packet lock. After a transfer with `in_last[g] = 0`, the grant stays on g; no other channel is granted until a transfer from g with `in_last[g] = 1`.
  - During the lock, `rr_ptr` does not advance. It advances to g+1 on the last beat.
  - The lock applies in both modes. A change of `mode` or `sel` during a lock is ignored until the lock releases.
- `RR_ARB_MUX_LOCK_EN` not defined: `in_last` is ignored and every beat is arbitrated independently. No lock register is built.

## Test plan
- Reset and static basics:
  - Assert reset with CHANNELS=4, WIDTH=32 → `out_valid = 0`, `out_data = 0`, `in_ready = 4'b0000`.
  - Release reset; set mode 0, `sel = 2`, `in_valid = 4'b0100`, data 0xA5A5A5A5 → `in_ready = 4'b0100`.
  - Next cycle: `out_data = 0xA5A5A5A5`, `out_sel = 2`.
- Round-robin fairness: mode 1, all four channels valid continuously, `out_ready = 1` → grants 0, 1, 2, 3, 0, … on consecutive cycles; `out_sel` follows one cycle later.
- Backpressure:
  - Hold `out_ready = 0` with `out_valid = 1` → `in_ready = 0` and the output stays stable for 5 cycles.
  - Raise `out_ready` → the next beat is captured on the same edge with no bubble.
- Wrap and skip: mode 1, `rr_ptr = 3`, `in_valid = 4'b0010` → channel 1 granted, then `rr_ptr = 2`.
- Static out-of-range: CHANNELS=3, `sel = 3`, all channels valid → `in_ready = 0`; `out_valid` falls to 0 after the pending beat is consumed.
- Packet lock (with `RR_ARB_MUX_LOCK_EN` defined):
  - Channel 0 sends 3 beats with `in_last = 0, 0, 1` while channel 1 is valid → all 3 channel-0 beats go out first.
  - Channel 1 is granted on the 4th cycle.
